// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter: round-robin N-master to 1-slave pipelined Wishbone arbiter
// with cycle-locked grants, outstanding tracking and a hung-cycle watchdog.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_rr_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int OW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_cyc,
  input  logic [NM-1:0]        m_stb,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*AW-1:0]     m_adr,
  input  logic [NM*DW/8-1:0]   m_sel,
  input  logic [NM*DW-1:0]     m_dat_w,
  output logic [DW-1:0]        m_dat_r,
  output logic [NM-1:0]        m_ack,
  output logic [NM-1:0]        m_err,
  output logic [NM-1:0]        m_stall,
  output logic [NM-1:0]        grant,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [AW-1:0]        s_adr,
  output logic [DW/8-1:0]      s_sel,
  output logic [DW-1:0]        s_dat_w,
  input  logic [DW-1:0]        s_dat_r,
  input  logic                 s_ack,
  input  logic                 s_err,
  input  logic                 s_stall
);

  localparam int SW  = DW / 8;
  localparam int LW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int WDW = $clog2(TIMEOUT + 2);
  localparam logic [OW-1:0]  OUT_MAX  = '1;
  localparam logic [WDW-1:0] WD_LIMIT = (TIMEOUT == 0) ? '0 : WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_t;

  state_t          state, state_nx;
  logic [NM-1:0]   grant_nx;
  logic [LW-1:0]   last, last_nx, pick;
  logic [OW-1:0]   outstanding, out_nx;
  logic [WDW-1:0]  wdog, wdog_nx;
  logic            found, full, resp, fire;
  logic            own_cyc, own_stb, own_we;
  logic [AW-1:0]   own_adr;
  logic [SW-1:0]   own_sel;
  logic [DW-1:0]   own_dat;
  logic [LW:0]     sum;

  assign m_dat_r = s_dat_r;

  // First requester at or after last+1, wrapping modulo NM.
  always_comb begin
    pick  = last;
    found = 1'b0;
    sum   = '0;
    for (int k = 1; k <= NM; k++) begin
      sum = {1'b0, last} + (LW+1)'(k);
      if (sum >= (LW+1)'(NM))
        sum = sum - (LW+1)'(NM);
      if (!found && m_cyc[sum[LW-1:0]]) begin
        pick  = sum[LW-1:0];
        found = 1'b1;
      end
    end
  end

  // Owner mux is driven by the registered owner index only.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_sel = '0;
    own_dat = '0;
    for (int i = 0; i < NM; i++) begin
      if (last == LW'(i)) begin
        own_cyc = m_cyc[i];
        own_stb = m_stb[i];
        own_we  = m_we[i];
        own_adr = m_adr[i*AW +: AW];
        own_sel = m_sel[i*SW +: SW];
        own_dat = m_dat_w[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    out_nx   = outstanding;
    wdog_nx  = wdog;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_w  = '0;
    m_ack    = '0;
    m_err    = '0;
    m_stall  = '1;
    full     = (outstanding == OUT_MAX);
    resp     = s_ack | s_err;
    fire     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|m_cyc) begin
          state_nx = ST_BUSY;
          last_nx  = pick;
          grant_nx = NM'(1) << pick;
          out_nx   = '0;
          wdog_nx  = '0;
        end
      end
      ST_BUSY: begin
        s_cyc         = own_cyc;
        s_stb         = own_stb & ~full;
        s_we          = own_we;
        s_adr         = own_adr;
        s_sel         = own_sel;
        s_dat_w       = own_dat;
        m_stall[last] = s_stall | full;
        m_ack[last]   = s_ack;
        fire          = (TIMEOUT != 0) && own_cyc && (outstanding != '0) &&
                        (wdog == WD_LIMIT) && !resp;
        m_err[last]   = s_err | fire;
        if (!own_cyc) begin
          // Owner abandoned the cycle; any late slave response is dropped.
          state_nx = ST_IDLE;
          grant_nx = '0;
          out_nx   = '0;
          wdog_nx  = '0;
        end else if (fire) begin
          state_nx = ST_ABORT;
          out_nx   = '0;
          wdog_nx  = '0;
        end else begin
          wdog_nx = ((outstanding != '0) && !resp) ? wdog + 1'b1 : '0;
          case ({s_stb & ~s_stall, resp && (outstanding != '0)})
            2'b10:   out_nx = outstanding + 1'b1;
            2'b01:   out_nx = outstanding - 1'b1;
            default: out_nx = outstanding;
          endcase
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_nx = ST_IDLE;
          grant_nx = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last        <= LW'(NM - 1);
      outstanding <= '0;
      wdog        <= '0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      last        <= last_nx;
      outstanding <= out_nx;
      wdog        <= wdog_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter: random masters and slave against a cycle-level model of
// the arbitration, outstanding-limit and watchdog rules. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_rr_arbiter;

  localparam int NM      = 3;
  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int SW      = DW / 8;
  localparam int OW      = 2;
  localparam int TIMEOUT = 8;
  localparam int OMAX    = (1 << OW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*SW-1:0]  m_sel;
  logic [NM*DW-1:0]  m_dat_w;
  logic [DW-1:0]     m_dat_r;
  logic [NM-1:0]     m_ack, m_err, m_stall, grant;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [SW-1:0]     s_sel;
  logic [DW-1:0]     s_dat_w, s_dat_r;
  logic              s_ack, s_err, s_stall;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .m_stall(m_stall), .grant(grant),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
    .s_stall(s_stall)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: owner is -1 when nobody holds the bus.
  int owner   = -1;
  int last    = NM - 1;
  int outst   = 0;
  int silent  = 0;
  bit aborted = 1'b0;
  int ack_pct = 60;
  bit [NM-1:0] just_dropped = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner   = -1;
    last    = NM - 1;
    outst   = 0;
    silent  = 0;
    aborted = 1'b0;
  endtask

  task automatic drive_inputs();
    bit active;
    active = (owner >= 0) && !aborted;
    for (int i = 0; i < NM; i++) begin
      if (m_cyc[i]) begin
        if ($urandom_range(0, 99) < ((owner == i && aborted) ? 50 : 8)) begin
          m_cyc[i]        = 1'b0;
          just_dropped[i] = 1'b1;
        end
      end else if (just_dropped[i]) begin
        just_dropped[i] = 1'b0;
      end else if ($urandom_range(0, 99) < 30) begin
        m_cyc[i] = 1'b1;
      end
      m_stb[i] = m_cyc[i] && ($urandom_range(0, 99) < 60);
      m_we[i]  = 1'($urandom);
    end
    m_adr   = NM*AW'($urandom);
    m_sel   = NM*SW'($urandom);
    m_dat_w = {$urandom, $urandom};
    s_dat_r = DW'($urandom);
    s_stall = ($urandom_range(0, 99) < 25);
    if (active && outst > 0) begin
      s_err = ($urandom_range(0, 99) < 3);
      s_ack = !s_err && ($urandom_range(0, 99) < ack_pct);
    end else if (active) begin
      s_ack = 1'b0;
      s_err = 1'b0;
    end else begin
      // Stray responses while idle or aborting must be ignored.
      s_ack = ($urandom_range(0, 99) < 15);
      s_err = !s_ack && ($urandom_range(0, 99) < 5);
    end
  endtask

  task automatic check_and_update();
    logic [NM-1:0] e_grant, e_ack, e_err, e_stall;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [SW-1:0] e_sel;
    logic [DW-1:0] e_dat;
    bit active, full, fire, resp, acc;
    e_grant = (owner >= 0) ? (NM'(1) << owner) : '0;
    e_ack   = '0;
    e_err   = '0;
    e_stall = '1;
    e_cyc   = 1'b0;
    e_stb   = 1'b0;
    e_we    = 1'b0;
    e_adr   = '0;
    e_sel   = '0;
    e_dat   = '0;
    fire    = 1'b0;
    active  = (owner >= 0) && !aborted;
    resp    = s_ack || s_err;
    if (active) begin
      full           = (outst == OMAX);
      e_cyc          = m_cyc[owner];
      e_stb          = m_stb[owner] && !full;
      e_we           = m_we[owner];
      e_adr          = m_adr[owner*AW +: AW];
      e_sel          = m_sel[owner*SW +: SW];
      e_dat          = m_dat_w[owner*DW +: DW];
      e_stall[owner] = s_stall || full;
      e_ack[owner]   = s_ack;
      fire           = e_cyc && (outst > 0) && (silent == TIMEOUT - 1) && !resp;
      e_err[owner]   = s_err || fire;
    end
    chk("grant",   64'(grant),   64'(e_grant));
    chk("s_cyc",   64'(s_cyc),   64'(e_cyc));
    chk("s_stb",   64'(s_stb),   64'(e_stb));
    chk("s_we",    64'(s_we),    64'(e_we));
    chk("s_adr",   64'(s_adr),   64'(e_adr));
    chk("s_sel",   64'(s_sel),   64'(e_sel));
    chk("s_dat_w", 64'(s_dat_w), 64'(e_dat));
    chk("m_ack",   64'(m_ack),   64'(e_ack));
    chk("m_err",   64'(m_err),   64'(e_err));
    chk("m_stall", 64'(m_stall), 64'(e_stall));
    chk("m_dat_r", 64'(m_dat_r), 64'(s_dat_r));

    if (owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        int c;
        c = (last + k) % NM;
        if (owner < 0 && m_cyc[c]) begin
          owner = c;
          last  = c;
        end
      end
      outst  = 0;
      silent = 0;
    end else if (aborted) begin
      if (!m_cyc[owner]) begin
        owner   = -1;
        aborted = 1'b0;
      end
    end else if (!m_cyc[owner]) begin
      owner  = -1;
      outst  = 0;
      silent = 0;
    end else if (fire) begin
      aborted = 1'b1;
      outst   = 0;
      silent  = 0;
    end else begin
      acc    = e_stb && !s_stall;
      silent = (outst > 0 && !resp) ? silent + 1 : 0;
      outst  = outst + int'(acc) - int'(resp && outst > 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".grant"},   64'(grant),   64'(0));
    chk({tag, ".s_cyc"},   64'(s_cyc),   64'(0));
    chk({tag, ".s_stb"},   64'(s_stb),   64'(0));
    chk({tag, ".m_ack"},   64'(m_ack),   64'(0));
    chk({tag, ".m_err"},   64'(m_err),   64'(0));
    chk({tag, ".m_stall"}, 64'(m_stall), 64'({NM{1'b1}}));
  endtask

  // Called one time unit after a rising edge; asserts rst between edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    m_adr   = '0;
    m_sel   = '0;
    m_dat_w = '0;
    s_dat_r = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 40 == 0)
        case ($urandom_range(0, 3))
          0:       ack_pct = 0;
          1:       ack_pct = 30;
          2:       ack_pct = 70;
          default: ack_pct = 100;
        endcase
      if (cyc == 1300 || cyc == 2700)
        do_reset();
      drive_inputs();
      #4;
      check_and_update();
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one pipelined Wishbone slave port between NM Wishbone masters, e.g. the ibex instruction and data ports contending for the debug-module slave bridge.
- Grants are round-robin, locked for the whole CYC assertion of the owning master.
- Tracks outstanding transfers and aborts a hung cycle with ERR after a programmable watchdog timeout.
- Sits between the masters' bus interfaces and the single slave-side Wishbone bridge.

Parameters:
- NM, 2, number of masters (2..8).
- AW, 30, word-address width.
- DW, 32, data width; SEL width is DW/8.
- OW, 4, outstanding-counter width; at most 2**OW-1 transfers in flight.
- TIMEOUT, 255, cycles without ACK/ERR while transfers are outstanding before abort; 0 disables the watchdog.

Ports:
- clk  in  1  bus clock.
- rst  in  1  reset, asynchronous, active-high.
- m_cyc  in  NM  per-master CYC.
- m_stb  in  NM  per-master STB.
- m_we  in  NM  per-master WE.
- m_adr  in  NM*AW  packed addresses; master i uses [i*AW +: AW].
- m_sel  in  NM*DW/8  packed byte selects.
- m_dat_w  in  NM*DW  packed write data.
- m_dat_r  out  DW  read data, broadcast to all masters (= s_dat_r).
- m_ack  out  NM  per-master ACK.
- m_err  out  NM  per-master ERR.
- m_stall  out  NM  per-master STALL.
- grant  out  NM  one-hot current owner; all zero when idle.
- s_cyc, s_stb, s_we  out  1  slave-side controls.
- s_adr  out  AW  slave-side address.
- s_sel  out  DW/8  slave-side byte selects.
- s_dat_w  out  DW  slave-side write data.
- s_dat_r  in  DW  slave read data.
- s_ack, s_err, s_stall  in  1  slave responses.

Behaviour:
Reset:
- On rst (async): state=IDLE, grant=0, last=NM-1, outstanding=0, wdog=0.
- While rst is high: s_cyc=s_stb=0, m_ack=m_err=0, m_stall all 1.

IDLE:
- Slave outputs are 0. Every m_stall bit is 1. Slave responses are ignored.
- If any m_cyc is set, pick the first requester searching from last+1 modulo NM upward. Register that index into grant and last, and go to BUSY next cycle.
- Grant latency is one cycle from CYC to the first cycle STB can be accepted.

BUSY (owner o):
- s_cyc=m_cyc[o], s_stb=m_stb[o], s_we/adr/sel/dat_w come from master o.
- m_stall[o]=s_stall; every other m_stall is 1.
- m_ack[o]=s_ack and m_err[o]=s_err, combinational. Other masters' ack/err are 0.
- outstanding increments on (s_stb & ~s_stall) and decrements on (s_ack | s_err). Both in the same cycle leaves it unchanged.
- If outstanding is at its maximum, m_stall[o] is forced to 1 and s_stb to 0.
- Owner drops m_cyc: go to IDLE next cycle and clear outstanding. A late ack or err from the slave is dropped, which is a legal Wishbone abort.
- No preemption: other requests wait regardless of priority.

Watchdog:
- In BUSY with outstanding!=0 and no ack/err, wdog increments; otherwise it clears.
- If TIMEOUT!=0 and wdog==TIMEOUT-1 with no response in that cycle: pulse m_err[o] for one cycle, force s_cyc=s_stb=0 from the next cycle, clear outstanding, go to ABORT.

ABORT:
- s_cyc=0, all m_stall=1, slave responses are ignored.
- Return to IDLE the cycle after m_cyc[o] falls. Fairness is kept because last=o.

Fairness and width rules:
- A master that holds CYC low for at least one cycle after its cycle ends cannot regain the bus before every other pending requester has been served once.
- m_dat_r is always s_dat_r; masters qualify it with their own ACK.
- The adr/sel/dat mux is indexed by the registered grant, never combinationally by request.

Test Plan:
- Single master 0 issues 3 pipelined reads with s_stall=0 and slave ACK one cycle after each accept -> grant=01 one cycle after CYC; three m_ack[0] pulses; m_stall[1]=1 throughout; grant=00 the cycle after CYC drops.
- Masters 0 and 1 both assert CYC from reset -> master 0 served first, then master 1, then master 0 again on continuous requests (last=0 → 1 → 0 alternation).
- Slave asserts s_stall for 2 cycles during owner writes -> m_stall[o] mirrors it; outstanding rises only on unstalled STB; it reaches 0 after the matching ACKs.
- TIMEOUT=8, slave never ACKs one accepted read -> exactly one m_err[o] pulse 8 cycles after acceptance; s_cyc=0 next cycle; no grant change until m_cyc[o] drops.
- OW=2 with 5 back-to-back STBs and slave ACK withheld -> m_stall[o]=1 after 3 accepts; stall releases on the first ACK.
- rst asserted mid-BUSY with 2 outstanding -> grant=0, s_cyc=0 and all m_stall=1 immediately without waiting for clk; after rst falls, a fresh request is granted normally.
